// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
//   Shared definitions for the MixColumns engine:
//     - fsm_state_t          : engine control states (IDLE / BUSY / DONE)
//     - FWD_COEF / INV_COEF  : first-row coefficients of the MixColumns and
//                              InvMixColumns matrices; later rows are rotations
//     - xtime()              : multiply by {02} in GF(2^8), polynomial 0x11B
//     - gf_mul_const()       : multiply by a small constant using xtime/XOR only
// -----------------------------------------------------------------------------
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

    // Row 0 coefficients; row r uses the coefficient at index (j - r) mod 4
    // for input byte j.
    localparam logic [3:0] FWD_COEF [4] = '{4'h2, 4'h3, 4'h1, 4'h1};
    localparam logic [3:0] INV_COEF [4] = '{4'he, 4'hb, 4'hd, 4'h9};

    // Multiply by {02}: shift left, reduce by 0x1B when bit 7 falls off.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a constant below {10}. Every coefficient in use fits in a
    // nibble, so the product is the XOR of at most four xtime powers. With a
    // constant k the loop collapses into a handful of XOR gates.
    function automatic logic [7:0] gf_mul_const(input logic [7:0] a,
                                                input logic [3:0] k);
        logic [7:0] acc;
        logic [7:0] pwr;
        acc = 8'h00;
        pwr = a;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) acc = acc ^ pwr;
            pwr = xtime(pwr);
        end
        return acc;
    endfunction

endpackage

// File: rtl/mix_column_unit.sv
// -----------------------------------------------------------------------------
// mix_column_unit
//   Combinational transform of one 32-bit AES state column.
//   Ports:
//     col_in  [31:0] : input column, row 0 in bits [31:24]
//     inv            : 0 = MixColumns, 1 = InvMixColumns
//     col_out [31:0] : transformed column, same byte order
// -----------------------------------------------------------------------------
module mix_column_unit
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    input  logic        inv,
    output logic [31:0] col_out
);

    logic [7:0] in_byte  [4];
    logic [7:0] fwd_byte [4];
    logic [7:0] inv_byte [4];

    // Both matrices are evaluated with constant coefficients and the result is
    // muxed; this keeps each product a fixed XOR network rather than a general
    // GF multiplier.
    // NOTE: every variable an always_comb block writes gets a value on entry,
    // so no path through the block can leave one unassigned and infer a latch.
    always_comb begin
        col_out = 32'h0;
        for (int j = 0; j < 4; j++) begin
            in_byte[j] = col_in[31 - 8*j -: 8];
        end
        for (int r = 0; r < 4; r++) begin
            fwd_byte[r] = 8'h00;
            inv_byte[r] = 8'h00;
            for (int j = 0; j < 4; j++) begin
                fwd_byte[r] = fwd_byte[r] ^ gf_mul_const(in_byte[j], FWD_COEF[(j + 4 - r) % 4]);
                inv_byte[r] = inv_byte[r] ^ gf_mul_const(in_byte[j], INV_COEF[(j + 4 - r) % 4]);
            end
            col_out[31 - 8*r -: 8] = inv ? inv_byte[r] : fwd_byte[r];
        end
    end

endmodule

// File: rtl/mix_columns_engine.sv
// -----------------------------------------------------------------------------
// mix_columns_engine
//   Iterative AES MixColumns / InvMixColumns engine. A state is captured in
//   IDLE, transformed COLS_PER_CYCLE columns per clock in BUSY (column 0
//   first), and held in DONE until the consumer takes it.
//   Parameters:
//     COLS_PER_CYCLE : columns per clock, 1, 2 or 4 (latency 4/COLS_PER_CYCLE)
//   Ports:
//     clk, rst_n         : clock, asynchronous active-low reset
//     in_valid/in_ready  : input handshake, in_ready high only in IDLE
//     in_state [127:0]   : column c in bits [127-32c -: 32], row 0 is the MSB
//     in_inv             : 0 = MixColumns, 1 = InvMixColumns
//     in_bypass          : pass the state through unchanged (final round)
//     out_valid/out_ready: output handshake, out_valid high only in DONE
//     out_state [127:0]  : result, same layout as in_state
// -----------------------------------------------------------------------------
module mix_columns_engine
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inv,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_illegal_cols
            $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    // The counter wraps to 0 after the last group; with four columns per
    // cycle the step is 4 and truncates to 0, which is exactly that wrap.
    localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);

    fsm_state_t  state;
    logic [31:0] col_q [4];
    logic        inv_q;
    logic        bypass_q;
    logic [1:0]  col_cnt;

    logic [1:0]  col_idx  [COLS_PER_CYCLE];
    logic [31:0] unit_out [COLS_PER_CYCLE];

    genvar k;
    generate
        for (k = 0; k < COLS_PER_CYCLE; k++) begin : g_unit
            // col_cnt is always a multiple of COLS_PER_CYCLE, so these indices
            // never wrap within one group.
            assign col_idx[k] = col_cnt + 2'(k);

            mix_column_unit u_mix_column_unit (
                .col_in  (col_q[col_idx[k]]),
                .inv     (inv_q),
                .col_out (unit_out[k])
            );
        end
    endgenerate

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            col_cnt  <= 2'd0;
            inv_q    <= 1'b0;
            bypass_q <= 1'b0;
            // NOTE: the column store drives out_state directly, so it is reset
            // like any control flop; a reset must clear the visible result and
            // discard an in-flight state.
            for (int i = 0; i < 4; i++) begin
                col_q[i] <= 32'h0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < 4; i++) begin
                            col_q[i] <= in_state[127 - 32*i -: 32];
                        end
                        inv_q    <= in_inv;
                        bypass_q <= in_bypass;
                        col_cnt  <= 2'd0;
                        state    <= BUSY;
                    end
                end

                BUSY: begin
                    // Bypass walks the same schedule so latency is unchanged;
                    // the columns are simply left as captured.
                    if (!bypass_q) begin
                        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
                            col_q[col_idx[j]] <= unit_out[j];
                        end
                    end
                    col_cnt <= col_cnt + CNT_STEP;
                    if (col_cnt == LAST_CNT) begin
                        state <= DONE;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Decoded straight from the state register, so both are glitch-free
    // registered outputs.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_state = {col_q[0], col_q[1], col_q[2], col_q[3]};

endmodule

// File: tb/tb_mix_columns_engine.sv
// -----------------------------------------------------------------------------
// tb_mix_columns_engine
//   Runs three engines (COLS_PER_CYCLE = 1, 2, 4) side by side on identical
//   stimulus. Expected results come from known-answer vectors and from a
//   reference model that evaluates the AES matrix product with log/antilog
//   tables over GF(2^8).
// -----------------------------------------------------------------------------
module tb_mix_columns_engine;

    localparam int NDUT = 3;
    localparam int CPC [NDUT] = '{1, 2, 4};

    localparam logic [7:0] FWD_M [4][4] = '{
        '{8'h02, 8'h03, 8'h01, 8'h01},
        '{8'h01, 8'h02, 8'h03, 8'h01},
        '{8'h01, 8'h01, 8'h02, 8'h03},
        '{8'h03, 8'h01, 8'h01, 8'h02}
    };
    localparam logic [7:0] INV_M [4][4] = '{
        '{8'h0e, 8'h0b, 8'h0d, 8'h09},
        '{8'h09, 8'h0e, 8'h0b, 8'h0d},
        '{8'h0d, 8'h09, 8'h0e, 8'h0b},
        '{8'h0b, 8'h0d, 8'h09, 8'h0e}
    };

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [127:0] in_state;
    logic         in_inv;
    logic         in_bypass;
    logic         out_ready;
    logic         in_ready  [NDUT];
    logic         out_valid [NDUT];
    logic [127:0] out_state [NDUT];

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] exp_t [256];
    logic [7:0] log_t [256];

    always #5 clk = ~clk;

    mix_columns_engine #(.COLS_PER_CYCLE(1)) u_dut_c1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_state(in_state), .in_inv(in_inv), .in_bypass(in_bypass),
        .out_valid(out_valid[0]), .out_ready(out_ready), .out_state(out_state[0])
    );
    mix_columns_engine #(.COLS_PER_CYCLE(2)) u_dut_c2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_state(in_state), .in_inv(in_inv), .in_bypass(in_bypass),
        .out_valid(out_valid[1]), .out_ready(out_ready), .out_state(out_state[1])
    );
    mix_columns_engine #(.COLS_PER_CYCLE(4)) u_dut_c4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]),
        .in_state(in_state), .in_inv(in_inv), .in_bypass(in_bypass),
        .out_valid(out_valid[2]), .out_ready(out_ready), .out_state(out_state[2])
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Antilog/log tables with generator {03}.
    task automatic build_tables();
        logic [7:0] x;
        x = 8'h01;
        for (int i = 0; i < 256; i++) log_t[i] = 8'h00;
        for (int i = 0; i < 255; i++) begin
            exp_t[i] = x;
            log_t[x] = 8'(i);
            x = x ^ ({x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00));
        end
        exp_t[255] = exp_t[0];
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return exp_t[(int'(log_t[a]) + int'(log_t[b])) % 255];
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic inv, input logic byp);
        logic [127:0] res;
        logic [7:0]   acc;
        if (byp) return s;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    acc = acc ^ gmul(inv ? INV_M[r][j] : FWD_M[r][j], s[127 - 32*c - 8*j -: 8]);
                end
                res[127 - 32*c - 8*r -: 8] = acc;
            end
        end
        return res;
    endfunction

    // One operation through all three engines. early_ready raises out_ready
    // right after acceptance; otherwise the result is held for `hold` extra
    // cycles while in_valid is toggled.
    task automatic transact(input string name, input logic [127:0] s, input logic inv,
                            input logic byp, input logic [127:0] exp,
                            input bit early_ready, input int hold);
        int           lat [NDUT];
        logic [127:0] got [NDUT];
        for (int d = 0; d < NDUT; d++) begin
            lat[d] = 0;
            got[d] = '0;
        end

        @(negedge clk);
        in_state  = s;
        in_inv    = inv;
        in_bypass = byp;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_state  = {$urandom, $urandom, $urandom, $urandom};
        in_inv    = 1'($urandom_range(0, 1));
        in_bypass = 1'($urandom_range(0, 1));
        out_ready = early_ready;

        for (int e = 1; e <= 8; e++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < NDUT; d++) begin
                if (out_valid[d] && lat[d] == 0) begin
                    lat[d] = e;
                    got[d] = out_state[d];
                end
            end
            if (!early_ready) in_valid = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;

        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("%s_lat_c%0d", name, CPC[d]), 128'(lat[d]), 128'(4 / CPC[d]));
            check($sformatf("%s_data_c%0d", name, CPC[d]), got[d], exp);
        end

        if (!early_ready) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                in_valid = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
                for (int d = 0; d < NDUT; d++) begin
                    check($sformatf("%s_hold%0d_data_c%0d", name, h, CPC[d]), out_state[d], exp);
                    check($sformatf("%s_hold%0d_vld_c%0d", name, h, CPC[d]), 128'(out_valid[d]), 128'(1));
                    check($sformatf("%s_hold%0d_rdy_c%0d", name, h, CPC[d]), 128'(in_ready[d]), 128'(0));
                end
            end
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("%s_idle_c%0d", name, CPC[d]),
                  128'({in_ready[d], out_valid[d]}), 128'(2'b10));
        end
    endtask

    task automatic reset_mid_busy();
        int spurious [NDUT];
        @(negedge clk);
        in_state  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
        in_inv    = 1'b0;
        in_bypass = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        // The single-column engine is now about to process column 2.
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("rst_vld_c%0d", CPC[d]), 128'(out_valid[d]), 128'(0));
            check($sformatf("rst_data_c%0d", CPC[d]), out_state[d], 128'h0);
            spurious[d] = 0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("rst_rdy_c%0d", CPC[d]), 128'(in_ready[d]), 128'(1));
        end
        for (int e = 0; e < 8; e++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < NDUT; d++) begin
                if (out_valid[d]) spurious[d]++;
            end
        end
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("rst_spurious_c%0d", CPC[d]), 128'(spurious[d]), 128'(0));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] s;
        logic         inv;
        logic         byp;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_state  = '0;
        in_inv    = 1'b0;
        in_bypass = 1'b0;
        out_ready = 1'b0;
        build_tables();

        #12;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("reset_vld_c%0d", CPC[d]), 128'(out_valid[d]), 128'(0));
            check($sformatf("reset_data_c%0d", CPC[d]), out_state[d], 128'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("reset_rdy_c%0d", CPC[d]), 128'(in_ready[d]), 128'(1));
        end

        transact("kat_fwd", 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, 1'b0,
                 128'h046681e5e0cb199a48f8d37a2806264c, 1'b0, 2);
        transact("kat_inv", 128'h046681e5e0cb199a48f8d37a2806264c, 1'b1, 1'b0,
                 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1, 0);
        transact("kat_fwd2", 128'hdb135345f20a225c01010101c6c6c6c6, 1'b0, 1'b0,
                 128'h8e4da1bc9fdc589d01010101c6c6c6c6, 1'b0, 0);
        transact("kat_bypass", 128'h00112233445566778899aabbccddeeff, 1'b0, 1'b1,
                 128'h00112233445566778899aabbccddeeff, 1'b0, 10);
        transact("kat_bypass_inv", 128'h00112233445566778899aabbccddeeff, 1'b1, 1'b1,
                 128'h00112233445566778899aabbccddeeff, 1'b1, 0);

        for (int t = 0; t < 24; t++) begin
            s   = {$urandom, $urandom, $urandom, $urandom};
            inv = 1'($urandom_range(0, 1));
            byp = ($urandom_range(0, 3) == 0);
            transact($sformatf("rnd%0d", t), s, inv, byp, model(s, inv, byp),
                     1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        reset_mid_busy();

        transact("post_reset", 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, 1'b0,
                 128'h046681e5e0cb199a48f8d37a2806264c, 1'b0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mix_columns_engine.md
MIX_COLUMNS_ENGINE -- requirements
Module: mix_columns_engine

Interface
REQ-001 SHALL have parameter COLS_PER_CYCLE, default 1, meaning the number of state columns transformed per clock; legal values are 1, 2 and 4.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1, meaning the input state is offered.
REQ-005 SHALL have port in_ready, output, 1, meaning the engine can accept a state.
REQ-006 SHALL have port in_state, input, 128, the AES state: column c is bits [127-32c -: 32], and row 0 is the most significant byte of each column.
REQ-007 SHALL have port in_inv, input, 1, selecting the transform: 0 = MixColumns, 1 = InvMixColumns.
REQ-008 SHALL have port in_bypass, input, 1, where 1 passes the state through unchanged (final round).
REQ-009 SHALL have port out_valid, output, 1, meaning the result is held on out_state.
REQ-010 SHALL have port out_ready, input, 1, meaning the consumer accepts the result.
REQ-011 SHALL have port out_state, output, 128, the result, in the same layout as in_state.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY and DONE; in_ready = (state==IDLE) and out_valid = (state==DONE).
REQ-013 SHALL, on IDLE with in_valid=1, capture in_state, in_inv and in_bypass into an internal register, clear the column counter, and go to BUSY.
REQ-014 SHALL, in BUSY, replace COLS_PER_CYCLE columns per cycle, starting at column 0 and ascending; the counter advances by COLS_PER_CYCLE.
REQ-015 SHALL, in BUSY, move to DONE on the cycle that processes column 3; out_valid rises exactly 4/COLS_PER_CYCLE clock edges after the acceptance edge.
REQ-016 SHALL, in DONE, hold out_state and out_valid stable until out_ready=1, then return to IDLE on that edge.
REQ-017 SHALL NOT accept a new input in the DONE-to-IDLE cycle; back-to-back throughput is one state per 4/COLS_PER_CYCLE+2 cycles minimum.
REQ-018 SHALL ignore in_valid, in_state, in_inv and in_bypass outside IDLE; changes to the inputs while BUSY do not affect the result.
REQ-019 SHALL compute forward columns as {2a^3b^c^d, a^2b^3c^d, a^b^2c^3d, 3a^b^c^2d} over GF(2^8) with polynomial 0x11B.
REQ-020 SHALL compute inverse columns with coefficients {0e,0b,0d,09}, rotated per row, in the same way.
REQ-021 SHALL implement the GF multiplication with xtime/XOR logic; no 256-entry lookup tables.
REQ-022 SHALL, when in_bypass=1 is captured, take the same latency as a normal operation and output the captured state bit-exact.
REQ-023 SHALL allow out_ready asserted early (before DONE), with no effect until DONE.
REQ-024 SHALL produce out_state identical for every legal COLS_PER_CYCLE; only the latency differs.

Reset
REQ-025 SHALL, on rst_n=0, immediately go to IDLE, with in_ready=1 after release, out_valid=0, out_state=128'h0 and column counter=0.
REQ-026 SHALL, on reset during BUSY or DONE, discard the in-flight state and produce no out_valid pulse after release.

Structure
REQ-027 SHALL place the xtime function, GF multiply-by-constant helpers, FSM state typedef and coefficient constants in shared package aes_pkg.
REQ-028 SHALL use one sub-module, mix_column_unit, instantiated COLS_PER_CYCLE times; it is combinational, takes a 32-bit column and inv, and outputs a 32-bit column.
REQ-029 SHALL fail elaboration for an illegal COLS_PER_CYCLE value.

Verification
REQ-030 SHALL cover forward mode, COLS_PER_CYCLE=1: in_state d4bf5d30e0b452aeb84111f11e2798e5 -> out_state 046681e5e0cb199a48f8d37a2806264c, with out_valid 4 edges after acceptance.
REQ-031 SHALL cover inverse mode: in_state 046681e5e0cb199a48f8d37a2806264c -> d4bf5d30e0b452aeb84111f11e2798e5; also db135345f20a225c01010101c6c6c6c6 (in_inv=0) -> 8e4da1bc9fdc589d01010101c6c6c6c6.
REQ-032 SHALL cover bypass: in_bypass=1 with in_state 00112233445566778899aabbccddeeff -> identical out_state, with the same latency as REQ-015.
REQ-033 SHALL cover backpressure: out_ready held 0 for 10 cycles in DONE -> out_state stable, in_ready=0 throughout, and in_valid pulses ignored.
REQ-034 SHALL cover the parameter sweep: COLS_PER_CYCLE of 2 and 4 with the REQ-030 vector -> same result, out_valid after 2 and 1 edges respectively.
REQ-035 SHALL cover reset mid-BUSY: rst_n pulled low during column 2 -> out_valid=0 and out_state=0 immediately, in_ready=1 after release, and no spurious output.
